// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter driving the select code of an 8:1 AXI-Stream mux.
// A grant is held from the first beat to the accepted tlast beat, or until MAX_BEATS forces release.
module axis_rr_pkt_arbiter #(
  parameter int         NUM_CH    = 8,
  parameter int         MAX_BEATS = 1024,
  parameter logic [7:0] SEL_BASE  = 8'd128,
  parameter logic [7:0] SEL_NONE  = 8'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arb_en,
  input  logic [NUM_CH-1:0] fifo_tvalid,
  input  logic              mux_tvalid,
  input  logic              mux_tlast,
  input  logic              m_tready,
  output logic [7:0]        bus_sel,
  output logic [NUM_CH-1:0] fifo_tready,
  output logic              grant_active,
  output logic              pkt_done,
  output logic              pkt_overrun,
  output logic [15:0]       pkt_count
);
  localparam int CW = $clog2(NUM_CH);
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   grant_idx_q, grant_idx_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [7:0]      bus_sel_d;
  logic            grant_active_d, pkt_done_d, pkt_overrun_d;
  logic [15:0]     pkt_count_d;
  logic [CW-1:0]   scan, pick;
  logic            pick_vld, accept;

  // Scan from the highest offset down so the request nearest rr_ptr wins last.
  always_comb begin
    scan     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan = rr_ptr_q + CW'(i);
      if (fifo_tvalid[scan]) begin
        pick     = scan;
        pick_vld = 1'b1;
      end
    end
  end

  assign accept = mux_tvalid & m_tready;

  always_comb begin
    state_d        = state_q;
    grant_idx_d    = grant_idx_q;
    rr_ptr_d       = rr_ptr_q;
    beat_cnt_d     = beat_cnt_q;
    bus_sel_d      = bus_sel;
    grant_active_d = grant_active;
    pkt_count_d    = pkt_count;
    pkt_done_d     = 1'b0;
    pkt_overrun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        bus_sel_d = SEL_NONE;
        if (arb_en && pick_vld) begin
          state_d        = GRANT;
          grant_idx_d    = pick;
          bus_sel_d      = SEL_BASE + 8'(pick);
          grant_active_d = 1'b1;
          beat_cnt_d     = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          // tlast wins over the beat limit, so a full-length packet is still "done".
          if (mux_tlast || beat_cnt_q == LAST_BEAT) begin
            state_d        = IDLE;
            bus_sel_d      = SEL_NONE;
            grant_active_d = 1'b0;
            rr_ptr_d       = grant_idx_q + CW'(1);
            pkt_done_d     = mux_tlast;
            pkt_overrun_d  = ~mux_tlast;
            pkt_count_d    = pkt_count + 16'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      bus_sel      <= SEL_NONE;
      grant_active <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_overrun  <= 1'b0;
      pkt_count    <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      bus_sel      <= bus_sel_d;
      grant_active <= grant_active_d;
      pkt_done     <= pkt_done_d;
      pkt_overrun  <= pkt_overrun_d;
      pkt_count    <= pkt_count_d;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_rdy
    assign fifo_tready[n] = (state_q == GRANT) && (grant_idx_q == CW'(n)) && m_tready;
  end
endmodule
